sdp_fifo: RTL and testbench
===========================

Name: sdp_fifo

Overview:
Parametrised single-clock synchronous FIFO built on an inferred simple dual-port block RAM (one write port, one read port). It generalises the fixed 256x32 SDP macro wrapper in data width and depth. It adds:
- pointer and occupancy management
- full/empty and programmable almost-full/almost-empty flags
- a selectable output pipeline register
- error pulses for overflow and underflow

It sits between pixel/feature producers and consumers in the tracker datapath, for example line buffers and blob-descriptor queues.

Parameters:
DATA_W, 32, data word width in bits (1..72)
ADDR_W, 8, address width; depth = 2**ADDR_W entries (4..12)
READ_MODE, 0, 0 = bypass (1-cycle read latency), 1 = pipeline (extra output register, 2-cycle latency)
AFULL_TH, 240, almost_full asserted when count >= AFULL_TH (1..2**ADDR_W)
AEMPTY_TH, 16, almost_empty asserted when count <= AEMPTY_TH (0..2**ADDR_W-1)

Ports:
clk  input  1  single clock, rising edge
resetn  input  1  asynchronous active-low reset
clr  input  1  synchronous flush, active high
wr_en  input  1  write request
din  input  DATA_W  write data
rd_en  input  1  read request
dout  output  DATA_W  read data
dout_valid  output  1  dout carries a newly read word this cycle
full  output  1  count == 2**ADDR_W
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  ADDR_W+1  current occupancy
overflow  output  1  1-cycle pulse: write rejected because full
underflow  output  1  1-cycle pulse: read rejected because empty

Behaviour:
- One clock domain. Reset is asynchronous and active-low (resetn).
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = (AFULL_TH == 0 ? 1 : 0), which evaluates to 0 for all legal values
  - dout = 0, dout_valid = 0, overflow = 0, underflow = 0, pipeline stage cleared
- RAM contents are not reset.
- Pointers are ADDR_W bits and wrap naturally modulo depth. Occupancy is the registered count, ADDR_W+1 bits.
- Accept rules, evaluated on the registered flags at the clock edge:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
- Simultaneous events:
  - Full with wr_en and rd_en: read accepted, write rejected, overflow pulses, count becomes depth-1.
  - Empty with wr_en and rd_en: write accepted, read rejected, underflow pulses, count becomes 1.
  - Otherwise, with both accepted, count is unchanged and both pointers advance.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged otherwise. All flags are registered and derived from the next count value, so they are valid in the cycle after the edge.
- Write: on wr_acc, RAM[wr_ptr] <= din, then wr_ptr += 1.
- Read, READ_MODE 0: on rd_acc, dout <= RAM[rd_ptr] at the same edge, rd_ptr += 1. dout_valid = 1 in the following cycle.
- Read, READ_MODE 1: the RAM output is registered once more. dout and dout_valid appear 2 cycles after the rd_en cycle. The pipeline stage advances every cycle; there is no stall.
- dout holds its last value when no read occurs. dout_valid is 0 in every cycle without a fresh word.
- Read-during-write hazard cannot occur: a read is only accepted for an entry written on an earlier edge, because a write and read in the same cycle at equal pointers implies empty, and the read is then rejected.
- clr, synchronous:
  - resets pointers, count and flags to their reset values
  - clears dout_valid and the pipeline valid bit
  - has priority over wr_en and rd_en in the same cycle; neither is accepted and no error pulse is raised
  - dout data is retained
- resetn asserted mid-operation clears state immediately, regardless of clk. Words in flight are discarded.
- overflow and underflow are single-cycle registered pulses, one per rejected request.

Test Plan:
- Reset, then write 5 words 0x11..0x15 back-to-back (READ_MODE 0) -> count = 5, empty = 0. Issue 5 reads -> dout = 0x11..0x15 one cycle after each rd_en, dout_valid high for 5 consecutive cycles, then empty = 1.
- Fill 256 entries (ADDR_W = 8) -> full = 1 after the 256th write, almost_full rises when count reaches 240. A 257th write gives an overflow pulse and count stays 256.
- At full, assert wr_en and rd_en together -> read returns the oldest word, overflow = 1, count = 255. At empty, assert both -> underflow = 1, count = 1, the next read returns the written word.
- Wrap-around: 300 interleaved write/read pairs with an incrementing pattern -> output sequence matches input with no loss, and count never exceeds 1 for a write-then-read-same-cycle stream.
- READ_MODE = 1, DATA_W = 16, ADDR_W = 4 -> a read of 0xBEEF gives dout = 0xBEEF with dout_valid exactly 2 cycles after rd_en. full asserts at count 16.
- Assert clr with count = 7 and wr_en high -> next cycle count = 0, empty = 1, no write taken. Pulse resetn low mid-burst, asynchronously between edges -> all flags, count and dout_valid clear immediately.

Source files
------------

// File: rtl/sdp_fifo.sv
// rtl/sdp_fifo.sv - single-clock FIFO on an inferred simple dual-port RAM
module sdp_fifo #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int READ_MODE = 0,
  parameter int AFULL_TH  = 240,
  parameter int AEMPTY_TH = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C   = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C  = AEMPTY_TH[ADDR_W:0];
  localparam logic            AFULL_RST = (AFULL_TH == 0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_afull;
  logic              r_aempty;
  logic              r_ovf;
  logic              r_unf;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_valid;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W:0]   w_count_nxt;

  // clr wins over both requests, so neither is accepted in a flush cycle
  assign w_wr_acc = wr_en & ~r_full  & ~clr;
  assign w_rd_acc = rd_en & ~r_empty & ~clr;

  // next occupancy: flags are derived from this so they are valid right after the edge
  always_comb begin
    w_count_nxt = r_count;
    if (clr) begin
      w_count_nxt = '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // RAM write port; contents are deliberately not reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // pointers, occupancy, registered flags and error pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= AFULL_RST;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (clr) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DEPTH_C);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= AFULL_C);
      r_aempty <= (w_count_nxt <= AEMPTY_C);
      r_ovf    <= wr_en & r_full  & ~clr;
      r_unf    <= rd_en & r_empty & ~clr;
    end
  end

  // RAM read port register; data holds when no read is accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) r_s1_data <= r_mem[r_rd_ptr];
    end
  end

  generate
    if (READ_MODE == 1) begin : g_pipe
      logic [DATA_W-1:0] r_s2_data;
      logic              r_s2_valid;

      // extra output stage, free-running with no stall; clr drops the word in flight
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_s2_data  <= '0;
          r_s2_valid <= 1'b0;
        end else if (clr) begin
          r_s2_valid <= 1'b0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) r_s2_data <= r_s1_data;
        end
      end

      assign dout       = r_s2_data;
      assign dout_valid = r_s2_valid;
    end else begin : g_byp
      assign dout       = r_s1_data;
      assign dout_valid = r_s1_valid;
    end
  endgenerate

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_sdp_fifo.sv
// tb/tb_sdp_fifo.sv - self-checking bench for sdp_fifo in bypass and pipeline modes
module tb_sdp_fifo;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 256x32, bypass
  logic        clr_a = 1'b0, wr_a = 1'b0, rd_a = 1'b0;
  logic [31:0] din_a = '0;
  logic [31:0] dout_a;
  logic        dv_a, full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a;
  logic [8:0]  count_a;

  // DUT B: 16x16, pipelined
  logic        clr_b = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
  logic [15:0] din_b = '0;
  logic [15:0] dout_b;
  logic        dv_b, full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b;
  logic [4:0]  count_b;

  sdp_fifo #(.DATA_W(32), .ADDR_W(8), .READ_MODE(0), .AFULL_TH(240), .AEMPTY_TH(16)) u_a (
    .clk(clk), .resetn(resetn), .clr(clr_a), .wr_en(wr_a), .din(din_a), .rd_en(rd_a),
    .dout(dout_a), .dout_valid(dv_a), .full(full_a), .empty(empty_a),
    .almost_full(afull_a), .almost_empty(aempty_a), .count(count_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  sdp_fifo #(.DATA_W(16), .ADDR_W(4), .READ_MODE(1), .AFULL_TH(12), .AEMPTY_TH(2)) u_b (
    .clk(clk), .resetn(resetn), .clr(clr_b), .wr_en(wr_b), .din(din_b), .rd_en(rd_b),
    .dout(dout_b), .dout_valid(dv_b), .full(full_b), .empty(empty_b),
    .almost_full(afull_b), .almost_empty(aempty_b), .count(count_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference models: stored contents, occupancy, and expected read words (scoreboard)
  int          ma_cnt = 0;
  logic [31:0] ma_q[$];
  logic [31:0] sa_q[$];
  int          mb_cnt = 0;
  logic [15:0] mb_q[$];
  logic [15:0] sb_q[$];
  logic        mb_pend = 1'b0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [8:0]  exp_count;
    logic        exp_empty;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_a(input logic wr, input logic rd, input logic cl, input logic [31:0] d);
    logic eov, eun, wacc, racc;
    wr_a = wr; rd_a = rd; clr_a = cl; din_a = d;
    eov = 1'b0; eun = 1'b0; wacc = 1'b0; racc = 1'b0;
    if (cl) begin
      ma_q.delete();
      ma_cnt = 0;
    end else begin
      eov  = wr && (ma_cnt == 256);
      eun  = rd && (ma_cnt == 0);
      wacc = wr && !eov;
      racc = rd && !eun;
      if (racc) sa_q.push_back(ma_q.pop_front());
      if (wacc) ma_q.push_back(d);
      ma_cnt = ma_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
    end
    @(posedge clk);
    #1;
    chk("a_count", count_a, ma_cnt);
    chk("a_empty", empty_a, ma_cnt == 0);
    chk("a_full", full_a, ma_cnt == 256);
    chk("a_afull", afull_a, ma_cnt >= 240);
    chk("a_aempty", aempty_a, ma_cnt <= 16);
    chk("a_overflow", ovf_a, eov);
    chk("a_underflow", unf_a, eun);
    chk("a_dout_valid", dv_a, racc);
    if (dv_a) begin
      if (sa_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_dout_unexpected: actual %0h required none", dout_a);
      end else begin
        chk("a_dout", dout_a, sa_q.pop_front());
      end
    end
    wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic step_b(input logic wr, input logic rd, input logic cl, input logic [15:0] d);
    logic eov, eun, wacc, racc, ev;
    wr_b = wr; rd_b = rd; clr_b = cl; din_b = d;
    eov = 1'b0; eun = 1'b0; wacc = 1'b0; racc = 1'b0;
    if (cl) begin
      mb_q.delete(); sb_q.delete();
      mb_cnt = 0; ev = 1'b0; mb_pend = 1'b0;
    end else begin
      eov  = wr && (mb_cnt == 16);
      eun  = rd && (mb_cnt == 0);
      wacc = wr && !eov;
      racc = rd && !eun;
      if (racc) sb_q.push_back(mb_q.pop_front());
      if (wacc) mb_q.push_back(d);
      mb_cnt = mb_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
      ev = mb_pend;
      mb_pend = racc;
    end
    @(posedge clk);
    #1;
    chk("b_count", count_b, mb_cnt);
    chk("b_empty", empty_b, mb_cnt == 0);
    chk("b_full", full_b, mb_cnt == 16);
    chk("b_afull", afull_b, mb_cnt >= 12);
    chk("b_aempty", aempty_b, mb_cnt <= 2);
    chk("b_overflow", ovf_b, eov);
    chk("b_underflow", unf_b, eun);
    chk("b_dout_valid", dv_b, ev);
    if (dv_b) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_dout_unexpected: actual %0h required none", dout_b);
      end else begin
        chk("b_dout", dout_b, sb_q.pop_front());
      end
    end
    wr_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b0, 32'h11 + 32'(i), 9'(i + 1), 1'b0};
    for (int i = 0; i < 5; i++) tbl[5 + i] = '{1'b0, 1'b1, 32'h0, 9'(4 - i), (i == 4)};
    tbl[10] = '{1'b1, 1'b1, 32'h99, 9'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'h0, 9'd0, 1'b1};

    // reset values
    #23;
    chk("rst_count", count_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_aempty", aempty_a, 1);
    chk("rst_afull", afull_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_dout_valid", dv_a, 0);
    chk("rst_ovf_unf", {ovf_a, unf_a}, 0);
    chk("rst_b_dout_valid", dv_b, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // table: 5 writes, 5 reads, then wr+rd at empty
    for (int i = 0; i < 12; i++) begin
      step_a(tbl[i].wr, tbl[i].rd, 1'b0, tbl[i].din);
      chk("tbl_count", count_a, tbl[i].exp_count);
      chk("tbl_empty", empty_a, tbl[i].exp_empty);
    end

    // fill to full, overflow, then wr+rd at full
    for (int i = 0; i < 256; i++) step_a(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i));
    chk("fill_full", full_a, 1);
    step_a(1'b1, 1'b0, 1'b0, 32'hDEAD);
    chk("ovf_count", count_a, 256);
    step_a(1'b1, 1'b1, 1'b0, 32'hBEEF);
    chk("full_rw_dout", dout_a, 32'h1000);
    chk("full_rw_count", count_a, 255);
    for (int i = 0; i < 255; i++) step_a(1'b0, 1'b1, 1'b0, 32'h0);
    step_a(1'b1, 1'b1, 1'b0, 32'hABCD);
    chk("empty_rw_unf", unf_a, 1);
    step_a(1'b0, 1'b1, 1'b0, 32'h0);
    chk("empty_rw_dout", dout_a, 32'hABCD);

    // wrap-around stream with simultaneous write/read
    step_a(1'b1, 1'b0, 1'b0, 32'h1FFF);
    for (int i = 0; i < 300; i++) step_a(1'b1, 1'b1, 1'b0, 32'h2000 + 32'(i));
    step_a(1'b0, 1'b1, 1'b0, 32'h0);

    // clr with count 7 and a write pending
    for (int i = 0; i < 7; i++) step_a(1'b1, 1'b0, 1'b0, 32'h3000 + 32'(i));
    step_a(1'b1, 1'b0, 1'b1, 32'hFFFF);
    chk("clr_count", count_a, 0);
    chk("clr_empty", empty_a, 1);
    step_a(1'b0, 1'b1, 1'b0, 32'h0);

    // asynchronous reset mid-burst, between edges
    for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0, 1'b0, 32'h4000 + 32'(i));
    wr_a = 1'b1; rd_a = 1'b1; din_a = 32'h4444;
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_count", count_a, 0);
    chk("arst_empty", empty_a, 1);
    chk("arst_full", full_a, 0);
    chk("arst_aempty", aempty_a, 1);
    chk("arst_dout_valid", dv_a, 0);
    chk("arst_dout", dout_a, 0);
    ma_q.delete(); sa_q.delete(); ma_cnt = 0;
    wr_a = 1'b0; rd_a = 1'b0;
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    step_a(1'b0, 1'b1, 1'b0, 32'h0);

    // pipelined instance: 2-cycle latency, fill, drain, clr
    step_b(1'b1, 1'b0, 1'b0, 16'hBEEF);
    step_b(1'b0, 1'b1, 1'b0, 16'h0);
    chk("b_lat1_valid", dv_b, 0);
    step_b(1'b0, 1'b0, 1'b0, 16'h0);
    chk("b_lat2_valid", dv_b, 1);
    chk("b_lat2_dout", dout_b, 16'hBEEF);
    for (int i = 0; i < 17; i++) step_b(1'b1, 1'b0, 1'b0, 16'hA000 + 16'(i));
    chk("b_full16", full_b, 1);
    for (int i = 0; i < 16; i++) step_b(1'b0, 1'b1, 1'b0, 16'h0);
    step_b(1'b0, 1'b0, 1'b0, 16'h0);
    step_b(1'b1, 1'b0, 1'b0, 16'h5555);
    step_b(1'b0, 1'b1, 1'b0, 16'h0);
    step_b(1'b1, 1'b0, 1'b1, 16'h0);
    chk("b_clr_valid", dv_b, 0);
    step_b(1'b0, 1'b0, 1'b0, 16'h0);

    chk("a_scoreboard_left", sa_q.size(), 0);
    chk("b_scoreboard_left", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
